// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM states, note word layout,
// Avalon register map and status/control bit positions.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PLAY    = 2'd2,
    SILENCE = 2'd3
  } state_t;

  localparam int NOTE_FREQ_LSB = 0;
  localparam int NOTE_FREQ_MSB = 15;
  localparam int NOTE_DUR_LSB  = 16;
  localparam int NOTE_DUR_MSB  = 31;

  localparam logic ADDR_NOTE = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_CLEAR   = 0;
  localparam int CTRL_CLR_OVF = 1;

  localparam int STAT_BUSY  = 8;
  localparam int STAT_OVF   = 9;
  localparam int STAT_EMPTY = 10;
  localparam int STAT_FULL  = 11;

endpackage

// File: rtl/note_fifo.sv
// Show-ahead FIFO for queued note words; clear has priority over push and pop.
module note_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/note_sequencer.sv
// Avalon-fed note queue that strobes frequencies into the tone generator and
// holds each note for its duration in milliseconds.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int FCLK  = 50000000,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        tg_write,
  output logic [31:0] tg_writedata
);

  localparam int P  = FCLK / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            ctrl_wr;
  logic            clear;
  logic            clr_ovf;
  logic            pop;
  logic            strobe;
  logic            strobe_note;
  logic            cnt_clr;
  logic            cnt_adv;
  logic            ms_done;
  logic            ovf;
  logic [31:0]     fifo_rd_data;
  logic [LW-1:0]   fifo_level;
  logic            fifo_empty;
  logic            fifo_full;
  logic [31:0]     note_p0;
  logic [15:0]     note_dur;
  logic [15:0]     note_freq;
  logic [PW-1:0]   pre_p0;
  logic [15:0]     ms_p0;
  logic [31:0]     status;

  assign push     = avs_write && (avs_address == ADDR_NOTE);
  assign ctrl_wr  = avs_write && (avs_address == ADDR_CTRL);
  assign clear    = ctrl_wr && avs_writedata[CTRL_CLEAR];
  assign clr_ovf  = ctrl_wr && avs_writedata[CTRL_CLR_OVF];
  assign note_dur  = note_p0[NOTE_DUR_MSB:NOTE_DUR_LSB];
  assign note_freq = note_p0[NOTE_FREQ_MSB:NOTE_FREQ_LSB];

  note_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (avs_writedata),
    .pop       (pop),
    .clear     (clear),
    .rd_data   (fifo_rd_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // PLAY is entered one cycle after the LOAD strobe and the next strobe comes
  // one cycle after PLAY ends, so PLAY spans D*P-1 cycles: end at ms D-1, tick P-2.
  assign ms_done = (ms_p0 == (note_dur - 16'd1)) && (pre_p0 == PW'(P - 2));

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    strobe      = 1'b0;
    strobe_note = 1'b0;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (note_dur == 16'd0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = SILENCE;
          end
        end else begin
          strobe      = 1'b1;
          strobe_note = 1'b1;
          cnt_clr     = 1'b1;
          state_nxt   = PLAY;
        end
      end
      PLAY: begin
        if (ms_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = SILENCE;
          end
        end else begin
          cnt_adv = 1'b1;
        end
      end
      SILENCE: begin
        strobe    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // CLEAR aborts whatever is in flight; a running sequence ends with one zero strobe.
    if (clear) begin
      pop         = 1'b0;
      strobe      = 1'b0;
      strobe_note = 1'b0;
      cnt_clr     = 1'b0;
      cnt_adv     = 1'b0;
      state_nxt   = (state == IDLE) ? IDLE : SILENCE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) note_p0 <= fifo_rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_p0 <= '0;
      ms_p0  <= '0;
    end else if (cnt_clr) begin
      pre_p0 <= '0;
      ms_p0  <= '0;
    end else if (cnt_adv) begin
      if (pre_p0 == PW'(P - 1)) begin
        pre_p0 <= '0;
        ms_p0  <= ms_p0 + 16'd1;
      end else begin
        pre_p0 <= pre_p0 + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tg_write     <= 1'b0;
      tg_writedata <= '0;
    end else begin
      tg_write <= strobe;
      if (strobe) tg_writedata <= strobe_note ? {16'b0, note_freq} : 32'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else if (push && fifo_full) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    status             = '0;
    status[7:0]        = 8'(fifo_level);
    status[STAT_BUSY]  = (state != IDLE);
    status[STAT_OVF]   = ovf;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= status;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at FCLK=8000 (8-cycle ms) and DEPTH=4.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        tg_write;
  logic [31:0] tg_writedata;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          s_cyc[$];
  logic [31:0] s_dat[$];

  note_sequencer #(
    .FCLK  (8000),
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .tg_write      (tg_write),
    .tg_writedata  (tg_writedata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tg_write === 1'b1) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(tg_writedata);
    end
  end

  function automatic int cyc_at(int i);
    return (i < s_cyc.size()) ? s_cyc[i] : -1000;
  endfunction

  function automatic logic [31:0] dat_at(int i);
    return (i < s_dat.size()) ? s_dat[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic log_clear();
    s_cyc.delete();
    s_dat.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic avs_wr(input logic a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(output logic [31:0] d);
    avs_read = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int k;
    int c;
    reset         = 1'b0;
    avs_address   = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;

    // Power-on reset
    idle(3);
    chk("rst_tg_write", 32'(tg_write), 32'd0);
    chk("rst_tg_data", tg_writedata, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    reset = 1'b1;
    idle(1);
    avs_rd(rd);
    chk("idle_status", rd, 32'h0000_0400);

    // Single note 440 Hz for 3 ms
    log_clear();
    avs_wr(1'b0, {16'd3, 16'd440});
    k = cyc;
    idle(4);
    avs_rd(rd);
    chk("play_status", rd, 32'h0000_0500);
    idle(30);
    chk("single_count", 32'(s_cyc.size()), 32'd2);
    chk("single_t0", 32'(cyc_at(0) - k), 32'd2);
    chk("single_d0", dat_at(0), 32'd440);
    chk("single_t1", 32'(cyc_at(1) - k), 32'd26);
    chk("single_d1", dat_at(1), 32'd0);
    chk("single_hold", tg_writedata, 32'd0);
    avs_rd(rd);
    chk("single_done_status", rd, 32'h0000_0400);

    // Back-to-back queued notes
    log_clear();
    avs_wr(1'b0, {16'd2, 16'd262});
    k = cyc;
    avs_wr(1'b0, {16'd1, 16'd330});
    avs_wr(1'b0, {16'd4, 16'd392});
    idle(65);
    chk("b2b_count", 32'(s_cyc.size()), 32'd4);
    chk("b2b_t0", 32'(cyc_at(0) - k), 32'd2);
    chk("b2b_d0", dat_at(0), 32'd262);
    chk("b2b_gap1", 32'(cyc_at(1) - cyc_at(0)), 32'd16);
    chk("b2b_d1", dat_at(1), 32'd330);
    chk("b2b_gap2", 32'(cyc_at(2) - cyc_at(1)), 32'd8);
    chk("b2b_d2", dat_at(2), 32'd392);
    chk("b2b_gap3", 32'(cyc_at(3) - cyc_at(2)), 32'd32);
    chk("b2b_d3", dat_at(3), 32'd0);

    // Zero-duration note is skipped without a strobe
    log_clear();
    avs_wr(1'b0, {16'd0, 16'd500});
    k = cyc;
    avs_wr(1'b0, {16'd1, 16'd600});
    idle(20);
    chk("skip_count", 32'(s_cyc.size()), 32'd2);
    chk("skip_d0", dat_at(0), 32'd600);
    chk("skip_t0", 32'(cyc_at(0) - k), 32'd3);
    chk("skip_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd8);
    chk("skip_d1", dat_at(1), 32'd0);

    // CLEAR during the first note of a queue
    log_clear();
    avs_wr(1'b0, {16'd4, 16'd100});
    k = cyc;
    avs_wr(1'b0, {16'd4, 16'd200});
    avs_wr(1'b0, {16'd4, 16'd300});
    idle(5);
    avs_wr(1'b1, 32'h0000_0001);
    c = cyc;
    idle(60);
    chk("clr_count", 32'(s_cyc.size()), 32'd2);
    chk("clr_d0", dat_at(0), 32'd100);
    chk("clr_t0", 32'(cyc_at(0) - k), 32'd2);
    chk("clr_t1", 32'(cyc_at(1) - c), 32'd1);
    chk("clr_d1", dat_at(1), 32'd0);
    avs_rd(rd);
    chk("clr_status", rd, 32'h0000_0400);

    // Overflow while a long note plays, then CLR_OVF and CLEAR
    avs_wr(1'b0, {16'd100, 16'd1000});
    idle(3);
    log_clear();
    for (int i = 0; i < 5; i++) avs_wr(1'b0, {16'd1, 16'(i + 1)});
    avs_rd(rd);
    chk("ovf_status", rd, 32'h0000_0B04);
    avs_wr(1'b1, 32'h0000_0002);
    avs_rd(rd);
    chk("clr_ovf_status", rd, 32'h0000_0904);
    avs_wr(1'b1, 32'h0000_0001);
    c = cyc;
    idle(3);
    avs_rd(rd);
    chk("ovf_clear_status", rd, 32'h0000_0400);
    chk("ovf_clear_count", 32'(s_cyc.size()), 32'd1);
    chk("ovf_clear_t", 32'(cyc_at(0) - c), 32'd1);
    chk("ovf_clear_d", dat_at(0), 32'd0);

    // Asynchronous reset in the middle of PLAY
    avs_wr(1'b0, {16'd5, 16'd700});
    idle(10);
    chk("pre_rst_data", tg_writedata, 32'd700);
    avs_rd(rd);
    chk("pre_rst_status", rd, 32'h0000_0500);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_write", 32'(tg_write), 32'd0);
    chk("async_rst_data", tg_writedata, 32'd0);
    chk("async_rst_readdata", avs_readdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    log_clear();
    idle(40);
    chk("post_rst_quiet", 32'(s_cyc.size()), 32'd0);
    chk("post_rst_readdata", avs_readdata, 32'd0);
    avs_rd(rd);
    chk("post_rst_status", rd, 32'h0000_0400);
    avs_wr(1'b0, {16'd1, 16'd50});
    k = cyc;
    idle(15);
    chk("post_rst_count", 32'(s_cyc.size()), 32'd2);
    chk("post_rst_t0", 32'(cyc_at(0) - k), 32'd2);
    chk("post_rst_d0", dat_at(0), 32'd50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
